idli_sqi_ctrl_m: RTL

- Arbitrates two requesters, instruction fetch (port 0) and load/store (port 1), onto one SQI serial SRAM.
- Sequences each SQI transaction: chip select, command, address, dummy, data.
- One instance per memory (lo/hi). Drives the same sck/cs/sio-in/sio-out pins that the bench connects to the SQI memory model.
- Reads and writes are one 16-bit word each, transferred as 4 nibbles, MSB first.

---
 rtl/idli_sqi_ctrl_m.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/idli_sqi_ctrl_m.sv
// SQI serial SRAM controller: round-robin arbitration of fetch (p0) and load/store (p1),
// sequencing command, address, dummy and data nibbles for one 16-bit word per transaction.
module idli_sqi_ctrl_m #(
  parameter logic [7:0]  CMD_RD        = 8'h03,
  parameter logic [7:0]  CMD_WR        = 8'h02,
  parameter int unsigned DUMMY_NIBBLES = 2
) (
  input  logic        i_sqc_gck,
  input  logic        i_sqc_rst,
  input  logic        i_sqc_p0_vld,
  output logic        o_sqc_p0_rdy,
  input  logic        i_sqc_p0_wr,
  input  logic [15:0] i_sqc_p0_addr,
  input  logic [15:0] i_sqc_p0_data,
  input  logic        i_sqc_p1_vld,
  output logic        o_sqc_p1_rdy,
  input  logic        i_sqc_p1_wr,
  input  logic [15:0] i_sqc_p1_addr,
  input  logic [15:0] i_sqc_p1_data,
  output logic [1:0]  o_sqc_rsp_vld,
  output logic [15:0] o_sqc_rsp_data,
  output logic        o_sqc_sck,
  output logic        o_sqc_cs,
  output logic [3:0]  o_sqc_sio,
  output logic        o_sqc_sio_en,
  input  logic [3:0]  i_sqc_sio
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_GAP} state_t;

  localparam logic [2:0] DUMMY_LAST = (DUMMY_NIBBLES == 0) ? 3'd0 : 3'(DUMMY_NIBBLES - 1);

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  seg_last;
  logic        wr_q, port_q, last_q;
  logic [15:0] addr_q, data_q;
  logic [11:0] shift_q;
  logic [1:0]  rsp_vld_q;
  logic [15:0] rsp_data_q;
  logic        idle, gnt1, rdy0, rdy1, accept, active, seg_end, done;
  logic [7:0]  cmd;

  function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    nib = w[15:12];
      2'd1:    nib = w[11:8];
      2'd2:    nib = w[7:4];
      default: nib = w[3:0];
    endcase
  endfunction

  // last_q set means p1 was granted most recently, so p0 wins a tie
  assign idle   = (state_q == S_IDLE) & ~i_sqc_rst;
  assign gnt1   = i_sqc_p1_vld & (~i_sqc_p0_vld | ~last_q);
  assign rdy0   = idle & i_sqc_p0_vld & ~gnt1;
  assign rdy1   = idle & gnt1;
  assign accept = rdy0 | rdy1;

  assign active  = state_q inside {S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA};
  assign seg_end = phase_q & (cnt_q == seg_last);
  assign done    = seg_end & ((state_q == S_WDATA) | (state_q == S_RDATA));
  assign cmd     = wr_q ? CMD_WR : CMD_RD;

  assign o_sqc_p0_rdy   = rdy0;
  assign o_sqc_p1_rdy   = rdy1;
  assign o_sqc_cs       = ~active;
  assign o_sqc_sck      = active & phase_q;
  assign o_sqc_rsp_vld  = rsp_vld_q;
  assign o_sqc_rsp_data = rsp_data_q;

  always_comb begin
    seg_last = 3'd3;
    case (state_q)
      S_CMD:   seg_last = 3'd1;
      S_DUMMY: seg_last = DUMMY_LAST;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_CMD;
        phase_d = 1'b0;
        cnt_d   = '0;
      end
      S_GAP: state_d = S_IDLE;
      default: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d = cnt_q + 3'd1;
          if (seg_end) begin
            cnt_d = '0;
            case (state_q)
              S_CMD:   state_d = S_ADDR;
              S_ADDR:  state_d = wr_q ? S_WDATA : ((DUMMY_NIBBLES == 0) ? S_RDATA : S_DUMMY);
              S_DUMMY: state_d = S_RDATA;
              default: state_d = S_GAP;
            endcase
          end
        end
      end
    endcase
  end

  always_comb begin
    o_sqc_sio    = '0;
    o_sqc_sio_en = 1'b0;
    case (state_q)
      S_CMD: begin
        o_sqc_sio_en = 1'b1;
        o_sqc_sio    = cnt_q[0] ? cmd[3:0] : cmd[7:4];
      end
      S_ADDR: begin
        o_sqc_sio_en = 1'b1;
        o_sqc_sio    = nib(addr_q, cnt_q[1:0]);
      end
      S_WDATA: begin
        o_sqc_sio_en = 1'b1;
        o_sqc_sio    = nib(data_q, cnt_q[1:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_sqc_gck or posedge i_sqc_rst) begin
    if (i_sqc_rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_sqc_gck or posedge i_sqc_rst) begin
    if (i_sqc_rst) begin
      wr_q       <= 1'b0;
      port_q     <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      data_q     <= '0;
      shift_q    <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        wr_q   <= gnt1 ? i_sqc_p1_wr   : i_sqc_p0_wr;
        addr_q <= gnt1 ? i_sqc_p1_addr : i_sqc_p0_addr;
        data_q <= gnt1 ? i_sqc_p1_data : i_sqc_p0_data;
        port_q <= gnt1;
        last_q <= gnt1;
      end
      if ((state_q == S_RDATA) && phase_q)
        shift_q <= {shift_q[7:0], i_sqc_sio};
      rsp_vld_q <= done ? {port_q, ~port_q} : 2'b00;
      // final nibble joins the word directly from the pins on the completing edge
      if (done && (state_q == S_RDATA))
        rsp_data_q <= {shift_q, i_sqc_sio};
    end
  end

endmodule
